cpu_muldiv: RTL and testbench

//  Iterative multiply/divide unit between the register file read and write ports.

---
 rtl/cpu_muldiv_pkg.sv | 21 ++
 rtl/cpu_muldiv_if.sv | 27 ++
 rtl/cpu_muldiv_div_step.sv | 25 ++
 rtl/cpu_muldiv.sv | 175 +++++++++++++++++
 tb/tb_cpu_muldiv.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_muldiv_pkg.sv
// Shared width, counter width and encodings for the iterative multiply/divide unit.
// The datapath width is set here by XLEN; everything else derives from it.
package cpu_muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    OpMul  = 2'b00,
    OpMulh = 2'b01,
    OpDiv  = 2'b10,
    OpRem  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/cpu_muldiv_if.sv
// Request/write-back bundle between the register-file read side, the muldiv unit and
// the register-file write port.
interface cpu_muldiv_if;
  import cpu_muldiv_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_addr;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      wb_addr;
  logic            wb_en;

  modport master (
    output start, op, rs1_val, rs2_val, rd_addr,
    input  busy, done, result, wb_addr, wb_en
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_addr,
    output busy, done, result, wb_addr, wb_en
  );

endinterface

// File: rtl/cpu_muldiv_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module cpu_muldiv_div_step
  import cpu_muldiv_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic            qbit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          unused_rem_msb;

  // The incoming partial remainder is always below the divisor, so its MSB is zero.
  assign unused_rem_msb = rem_i[XLEN];

  assign shifted = {rem_i[XLEN-1:0], bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign qbit_o  = ~diff[XLEN];
  assign rem_o   = qbit_o ? diff : shifted;

endmodule

// File: rtl/cpu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle, XLEN steps per op.
// Define CPU_MULDIV_SIGNED_EN to honour op[2] as the signed MULH/DIV/REM select.
module cpu_muldiv
  import cpu_muldiv_pkg::*;
(
  input logic         clk,
  input logic         rst,
  cpu_muldiv_if.slave bus
);

  state_e            state_q;
  op_e               op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN:0]     hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              busy_q;
  logic              done_q;
  logic              wb_en_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        wb_addr_q;

  op_e               acc_op;
  logic              acc_div0;
  logic [XLEN-1:0]   acc_a;
  logic [XLEN-1:0]   acc_b;

  assign acc_op   = op_e'(bus.op[1:0]);
  assign acc_div0 = bus.op[1] && (bus.rs2_val == '0);

`ifdef CPU_MULDIV_SIGNED_EN
  logic acc_sgn;
  logic a_neg;
  logic b_neg;
  logic acc_neg;
  logic neg_q;

  // Low-half MUL is sign-agnostic, so only MULH/DIV/REM go through magnitudes.
  assign acc_sgn = bus.op[2] && (acc_op != OpMul);
  assign a_neg   = acc_sgn && bus.rs1_val[XLEN-1];
  assign b_neg   = acc_sgn && bus.rs2_val[XLEN-1];
  assign acc_a   = a_neg ? -bus.rs1_val : bus.rs1_val;
  assign acc_b   = b_neg ? -bus.rs2_val : bus.rs2_val;
  assign acc_neg = (acc_op == OpRem) ? a_neg : (a_neg ^ b_neg);
`else
  logic unused_op_sign;

  assign unused_op_sign = bus.op[2];
  assign acc_a          = bus.rs1_val;
  assign acc_b          = bus.rs2_val;
`endif

  // Datapath step: hi_q/lo_q hold {acc, multiplier} for MUL and {remainder, dividend} for DIV.
  logic              is_div;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem;
  logic              div_qbit;
  logic [XLEN:0]     step_hi;
  logic [XLEN-1:0]   step_lo;

  assign is_div  = (op_q == OpDiv) || (op_q == OpRem);
  assign mul_sum = lo_q[0] ? (hi_q + {1'b0, b_q}) : hi_q;

  cpu_muldiv_div_step u_div_step (
    .rem_i     (hi_q),
    .bit_i     (lo_q[XLEN-1]),
    .divisor_i (b_q),
    .rem_o     (div_rem),
    .qbit_o    (div_qbit)
  );

  always_comb begin
    if (is_div) begin
      step_hi = div_rem;
      step_lo = {lo_q[XLEN-2:0], div_qbit};
    end else begin
      step_hi = {1'b0, mul_sum[XLEN:1]};
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Result as seen after the final step, so it can be registered on the edge into DONE.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin_result;

  always_comb begin
    prod = {step_hi[XLEN-1:0], step_lo};
    quo  = step_lo;
    rem  = step_hi[XLEN-1:0];
`ifdef CPU_MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = -prod;
      quo  = -quo;
      rem  = -rem;
    end
`endif
    unique case (op_q)
      OpMul:   fin_result = prod[XLEN-1:0];
      OpMulh:  fin_result = prod[2*XLEN-1:XLEN];
      OpDiv:   fin_result = quo;
      OpRem:   fin_result = rem;
      default: fin_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      cnt_q     <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      result_q  <= '0;
      wb_addr_q <= '0;
`ifdef CPU_MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      wb_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q      <= acc_op;
            wb_addr_q <= bus.rd_addr;
            cnt_q     <= '0;
            b_q       <= acc_b;
            hi_q      <= '0;
            lo_q      <= acc_a;
`ifdef CPU_MULDIV_SIGNED_EN
            neg_q     <= acc_neg;
`endif
            if (acc_div0) begin
              // Divide by zero bypasses RUN; REM returns the raw dividend, DIV all-ones.
              state_q  <= StDone;
              done_q   <= 1'b1;
              wb_en_q  <= (bus.rd_addr != 5'd0);
              result_q <= (acc_op == OpRem) ? bus.rs1_val : '1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            wb_en_q  <= (wb_addr_q != 5'd0);
            result_q <= fin_result;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.result  = result_q;
  assign bus.wb_addr = wb_addr_q;

endmodule

// File: tb/tb_cpu_muldiv.sv
// Bench for cpu_muldiv: arithmetic/timing reference model checked every cycle, plus
// directed operations with hand-computed results and latencies.
module tb_cpu_muldiv;
  import cpu_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  cpu_muldiv_if bus();

  cpu_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Reference result straight from the arithmetic definition of each op.
  function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    bit          sgn;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [31:0] r;
`ifdef CPU_MULDIV_SIGNED_EN
    sgn = op[2] && (op[1:0] != 2'b00);
`else
    sgn = 1'b0;
`endif
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    if (op[1] && b == 32'd0) begin
      r = op[0] ? a : 32'hFFFF_FFFF;
    end else begin
      case (op[1:0])
        2'b00:   p = sa * sb;
        2'b01:   p = sa * sb;
        2'b10:   p = sa / sb;
        default: p = sa % sb;
      endcase
      r = (op[1:0] == 2'b01) ? p[63:32] : p[31:0];
    end
    return r;
  endfunction

  // Timing model: an op accepted at edge e completes at edge e+32 (e for divide by zero),
  // and the unit can take a new op from two edges after completion.
  int          cyc = 0;
  bit          armed = 1'b0;
  bit          m_pend = 1'b0;
  int          m_done_edge = 0;
  int          m_ready_edge = 0;
  logic [31:0] m_pend_res = '0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_wb_addr = '0;
  bit          m_exp_done = 1'b0;
  bit          m_clean = 1'b1;

  always @(posedge clk) begin
    cyc++;
    m_exp_done = 1'b0;
    if (rst) begin
      armed        = 1'b1;
      m_pend       = 1'b0;
      m_ready_edge = cyc + 1;
      m_wb_addr    = '0;
      m_clean      = 1'b1;
    end else if (armed) begin
      if (!m_pend && cyc >= m_ready_edge && bus.start) begin
        m_pend       = 1'b1;
        m_wb_addr    = bus.rd_addr;
        m_pend_res   = ref_calc(bus.op, bus.rs1_val, bus.rs2_val);
        m_done_edge  = (bus.op[1] && bus.rs2_val == 32'd0) ? cyc : cyc + 32;
        m_ready_edge = m_done_edge + 2;
      end
      if (m_pend && cyc == m_done_edge) begin
        m_pend     = 1'b0;
        m_exp_done = 1'b1;
        m_res      = m_pend_res;
        m_clean    = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("done", {31'd0, bus.done}, {31'd0, m_exp_done});
      chk("busy", {31'd0, bus.busy}, {31'd0, m_pend});
      chk("wb_addr", {27'd0, bus.wb_addr}, {27'd0, m_wb_addr});
      chk("wb_en", {31'd0, bus.wb_en}, {31'd0, m_exp_done && (m_wb_addr != 5'd0)});
      if (m_exp_done) chk("model_result", bus.result, m_res);
      if (m_clean) chk("result_cleared", bus.result, 32'd0);
    end
  end

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_lat, input bit spam);
    int n;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_addr = rd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.start   = spam && (n == 5 || n == 15);
      bus.rs1_val = ~a;
      bus.rs2_val = ~b;
      bus.rd_addr = ~rd;
    end while (!bus.done && n < 40);
    bus.start = 1'b0;
    if (!bus.done) $display("FAIL %s_timeout: no done after %0d cycles, want %0d", name, n,
                            exp_lat);
    chk(name, bus.result, exp);
    chk({name, "_lat"}, n, exp_lat);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.op      = 3'd0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_wb_addr", {27'd0, bus.wb_addr}, 32'd0);
    rst = 1'b0;

    run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 5'd3, 32'd42, 33, 1'b0);
    run_op("mul_ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 33, 1'b0);
    run_op("mulhu_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("mulhu_2e33", 3'b001, 32'h8000_0000, 32'd4, 5'd5, 32'd2, 33, 1'b0);
    run_op("mul_zero", 3'b000, 32'h1234_5678, 32'd0, 5'd6, 32'd0, 33, 1'b0);
    run_op("divu_100_7", 3'b010, 32'd100, 32'd7, 5'd8, 32'd14, 33, 1'b1);
    run_op("remu_100_7", 3'b011, 32'd100, 32'd7, 5'd9, 32'd2, 33, 1'b1);
    run_op("divu_5_0", 3'b010, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu_5_0_rd0", 3'b011, 32'd5, 32'd0, 5'd0, 32'd5, 1, 1'b0);
    run_op("mul_rd0", 3'b000, 32'd11, 32'd13, 5'd0, 32'd143, 33, 1'b0);
    run_op("divu_max_1", 3'b010, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu_hex", 3'b010, 32'h1234_5678, 32'h1000, 5'd12, 32'h0001_2345, 33, 1'b0);
    run_op("remu_hex", 3'b011, 32'h1234_5678, 32'h1000, 5'd13, 32'h0000_0678, 33, 1'b0);
    run_op("remu_small", 3'b011, 32'd3, 32'd10, 5'd14, 32'd3, 33, 1'b0);

    // Abort mid-run: reset sampled on RUN iteration 10.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = 3'b000;
    bus.rs1_val = 32'd5;
    bus.rs2_val = 32'd5;
    bus.rd_addr = 5'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    rst = 1'b0;
    run_op("mul_3x3", 3'b000, 32'd3, 32'd3, 5'd15, 32'd9, 33, 1'b0);

`ifdef CPU_MULDIV_SIGNED_EN
    run_op("div_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_m7_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 33, 1'b0);
    run_op("rem_ovf", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0, 33, 1'b0);
    run_op("mulh_m1_m1", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'd0, 33, 1'b0);
    run_op("mulh_m2_3", 3'b101, 32'hFFFF_FFFE, 32'd3, 5'd21, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_s_0", 3'b110, 32'hFFFF_FFF9, 32'd0, 5'd22, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("rem_s_0", 3'b111, 32'hFFFF_FFF9, 32'd0, 5'd23, 32'hFFFF_FFF9, 1, 1'b0);
`else
    run_op("div_opsign_ign", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'h7FFF_FFFC, 33, 1'b0);
    run_op("mulh_opsign_ign", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE, 33,
           1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
